// File: rtl/flash_audio_pkg.sv
// Shared types and constants for the flash audio streamer: FSM states, lane geometry,
// default playback window, and the lane-select helper.
package flash_audio_pkg;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        WAIT_TICK,
        EMIT,
        ADVANCE,
        STOPPED
    } state_t;

    localparam int LANES  = 2;
    localparam int LANE_W = 16;
    localparam int WORD_W = LANES * LANE_W;

    localparam int          DEF_ADDR_W     = 23;
    localparam logic [22:0] DEF_START_ADDR = 23'h0;
    localparam logic [22:0] DEF_END_ADDR   = 23'h7FFFF;

    // idx is the physical lane: 0 = bits 15:0, 1 = bits 31:16
    function automatic logic [LANE_W-1:0] lane_of(input logic [WORD_W-1:0] w, input logic idx);
        return idx ? w[WORD_W-1:LANE_W] : w[LANE_W-1:0];
    endfunction

endpackage

// File: rtl/flash_addr_sequencer.sv
// Holds the flash word address of the next fetch; steps +/-1 per word, wraps or sticks at
// the window edge, and reloads the direction-dependent window start on restart. 1-cycle update.
module flash_addr_sequencer
    import flash_audio_pkg::*;
#(
    parameter int                ADDR_W     = DEF_ADDR_W,
    parameter logic [ADDR_W-1:0] START_ADDR = ADDR_W'(DEF_START_ADDR),
    parameter logic [ADDR_W-1:0] END_ADDR   = ADDR_W'(DEF_END_ADDR)
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              load_i,
    input  logic              step_i,
    input  logic              dir_i,
    input  logic              loop_i,
    output logic [ADDR_W-1:0] next_addr_o,
    output logic              terminal_o
);

    localparam logic [ADDR_W-1:0] ONE = ADDR_W'(1);

    logic [ADDR_W-1:0] addr_q;
    logic [ADDR_W-1:0] addr_d;

    assign terminal_o  = dir_i ? (addr_q == START_ADDR) : (addr_q == END_ADDR);
    assign next_addr_o = addr_q;

    always_comb begin
        addr_d = addr_q;
        if (load_i) begin
            addr_d = dir_i ? END_ADDR : START_ADDR;
        end else if (step_i) begin
            if (terminal_o) begin
                addr_d = loop_i ? (dir_i ? END_ADDR : START_ADDR) : addr_q;
            end else begin
                addr_d = dir_i ? (addr_q - ONE) : (addr_q + ONE);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            addr_q <= START_ADDR;
        end else begin
            addr_q <= addr_d;
        end
    end

endmodule

// File: rtl/flash_audio_streamer.sv
// Fetches 32-bit flash words and plays each 16-bit lane (top SAMPLE_W bits) on sample_tick.
// All outputs registered; a tick with no word ready is dropped and reported as underrun.
module flash_audio_streamer
    import flash_audio_pkg::*;
#(
    parameter int                ADDR_W     = DEF_ADDR_W,
    parameter logic [ADDR_W-1:0] START_ADDR = ADDR_W'(DEF_START_ADDR),
    parameter logic [ADDR_W-1:0] END_ADDR   = ADDR_W'(DEF_END_ADDR),
    parameter int                SAMPLE_W   = 8
) (
    input  logic                clk50M,
    input  logic                reset,
    input  logic                sample_tick,
    input  logic                enable,
    input  logic                direction,
    input  logic                loop,
    input  logic                restart,
    output logic                rd_req,
    output logic [ADDR_W-1:0]   rd_addr,
    input  logic                rd_done,
    input  logic [WORD_W-1:0]   rd_data,
    output logic [SAMPLE_W-1:0] audio_out,
    output logic                audio_valid,
    output logic                word_done,
    output logic                end_pulse,
    output logic                underrun
);

    state_t              state_q, state_d;
    logic [WORD_W-1:0]   word_q, word_d;
    logic                lane_q, lane_d;
    logic                dir_q, dir_d;
    logic                discard_q;
    logic                rd_req_q, rd_req_d;
    logic [ADDR_W-1:0]   rd_addr_q;
    logic [SAMPLE_W-1:0] audio_q, audio_d;
    logic                audio_valid_q, audio_valid_d;
    logic                word_done_q, word_done_d;
    logic                end_pulse_q, end_pulse_d;
    logic                underrun_q, underrun_d;

    logic                seq_load, seq_step, seq_terminal;
    logic [ADDR_W-1:0]   seq_addr;
    logic                done_ok;
    logic [LANE_W-1:0]   cur_lane;

    flash_addr_sequencer #(
        .ADDR_W     (ADDR_W),
        .START_ADDR (START_ADDR),
        .END_ADDR   (END_ADDR)
    ) u_seq (
        .clk_i       (clk50M),
        .reset_i     (reset),
        .load_i      (seq_load),
        .step_i      (seq_step),
        .dir_i       (direction),
        .loop_i      (loop),
        .next_addr_o (seq_addr),
        .terminal_o  (seq_terminal)
    );

    // lane_q counts lanes played; the word's direction flips which physical lane that is
    assign cur_lane = lane_of(word_q, lane_q ^ dir_q);
    assign done_ok  = rd_done && !discard_q;

    always_comb begin
        state_d       = state_q;
        word_d        = word_q;
        lane_d        = lane_q;
        dir_d         = dir_q;
        audio_d       = audio_q;
        audio_valid_d = 1'b0;
        word_done_d   = 1'b0;
        end_pulse_d   = 1'b0;
        underrun_d    = 1'b0;
        seq_load      = 1'b0;
        seq_step      = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (enable) state_d = FETCH;
            end
            FETCH: begin
                if (sample_tick && enable) underrun_d = 1'b1;
                if (done_ok) begin
                    word_d  = rd_data;
                    dir_d   = direction;
                    lane_d  = 1'b0;
                    state_d = WAIT_TICK;
                end
            end
            WAIT_TICK: begin
                if (sample_tick && enable) state_d = EMIT;
            end
            EMIT: begin
                audio_d       = cur_lane[LANE_W-1 -: SAMPLE_W];
                audio_valid_d = 1'b1;
                if (lane_q) begin
                    state_d = ADVANCE;
                end else begin
                    lane_d  = 1'b1;
                    state_d = WAIT_TICK;
                end
            end
            ADVANCE: begin
                word_done_d = 1'b1;
                seq_step    = 1'b1;
                if (seq_terminal && !loop) begin
                    end_pulse_d = 1'b1;
                    state_d     = STOPPED;
                end else begin
                    state_d = enable ? FETCH : IDLE;
                end
            end
            STOPPED: begin
                state_d = STOPPED;
            end
            default: state_d = IDLE;
        endcase

        if (restart) begin
            state_d       = enable ? FETCH : IDLE;
            word_d        = '0;
            lane_d        = 1'b0;
            seq_load      = 1'b1;
            seq_step      = 1'b0;
            audio_valid_d = 1'b0;
            word_done_d   = 1'b0;
            end_pulse_d   = 1'b0;
            underrun_d    = 1'b0;
        end

        rd_req_d = (state_q == FETCH) && (state_d == FETCH) && !restart;
    end

    always_ff @(posedge clk50M) begin
        if (reset) begin
            state_q       <= IDLE;
            word_q        <= '0;
            lane_q        <= 1'b0;
            dir_q         <= 1'b0;
            discard_q     <= 1'b0;
            rd_req_q      <= 1'b0;
            rd_addr_q     <= START_ADDR;
            audio_q       <= '0;
            audio_valid_q <= 1'b0;
            word_done_q   <= 1'b0;
            end_pulse_q   <= 1'b0;
            underrun_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            word_q        <= word_d;
            lane_q        <= lane_d;
            dir_q         <= dir_d;
            discard_q     <= restart;
            rd_req_q      <= rd_req_d;
            rd_addr_q     <= seq_addr;
            audio_q       <= audio_d;
            audio_valid_q <= audio_valid_d;
            word_done_q   <= word_done_d;
            end_pulse_q   <= end_pulse_d;
            underrun_q    <= underrun_d;
        end
    end

    assign rd_req      = rd_req_q;
    assign rd_addr     = rd_addr_q;
    assign audio_out   = audio_q;
    assign audio_valid = audio_valid_q;
    assign word_done   = word_done_q;
    assign end_pulse   = end_pulse_q;
    assign underrun    = underrun_q;

endmodule
